prog_ram_player: RTL and testbench

Memory-side responder for the program-RAM load/play protocol. It accepts bytes on `data_to_memory`/`valid` and packs them into `N_BYTS`-byte note words. It stores the words in an internal RAM from address 0 or a selected start address, and raises `full` once the last entry is written. When `enable_l` is asserted it plays the stored words back, one word every `NOTE_CYC` clocks, and presents each word and its index to the buzzer stage.

---
 rtl/prog_ram_pkg.sv | 30 +++
 rtl/prog_ram_mem.sv | 54 +++++
 rtl/prog_ram_player.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_prog_ram_player.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ram_pkg.sv
// -----------------------------------------------------------------------------
// prog_ram_pkg
// Shared declarations for the program-RAM player: the playback/load state
// encoding, the default RAM depth, the default note-word type and a depth
// helper used to size the RAM from the octave count.
// -----------------------------------------------------------------------------
package prog_ram_pkg;

    // One RAM word per note of the seven-note scale, per octave.
    localparam int unsigned NOTES_PER_OCTAVE_C = 32'd7;
    localparam int unsigned NUM_OCTAV_C        = 32'd1;
    localparam int unsigned DEPTH_C            = NOTES_PER_OCTAVE_C * NUM_OCTAV_C;
    localparam int unsigned N_BYTS_C           = 32'd2;

    typedef logic [N_BYTS_C*8-1:0] note_word_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RCV       = 3'd1,
        FULL      = 3'd2,
        WORK      = 3'd3,
        STOP_WORK = 3'd4
    } state_t;

    // RAM depth in words for a given number of octaves.
    function automatic int unsigned depth_f(input int unsigned num_octav);
        return num_octav * NOTES_PER_OCTAVE_C;
    endfunction

endpackage

// File: rtl/prog_ram_mem.sv
// -----------------------------------------------------------------------------
// prog_ram_mem
// Single-port note RAM: synchronous write, registered read. The storage
// array is never reset (a loaded program survives reset); only the read
// data register is cleared. The read register holds its value whenever no
// read is requested, so it can serve directly as the player's note output.
//
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset of the read register
//   we_i     - write strobe, writes wdata_i to addr_i
//   re_i     - read strobe, loads rdata_o from addr_i on the next edge
//   addr_i   - shared read/write address
//   wdata_i  - write data
//   rdata_o  - registered read data
// -----------------------------------------------------------------------------
module prog_ram_mem
    import prog_ram_pkg::*;
#(
    parameter int          DW    = 16,
    parameter int          AW    = 3,
    parameter int unsigned DEPTH = DEPTH_C
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port: storage array, deliberately without reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read port: registered data, held between reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= {DW{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_ram_player.sv
// -----------------------------------------------------------------------------
// prog_ram_player
// Memory-side responder of the program-RAM load/play protocol. Bytes arrive
// LSB first and are packed into N_BYTS-byte note words, stored from address 0
// or a selected start address until the last RAM entry is written. While
// enable_l is high the stored words are played back, one every NOTE_CYC
// clocks, and each word is presented with its index.
//
// Build option: define PROG_RAM_LOOP_EN to make playback wrap from the last
// address back to the start address forever; otherwise playback stops after
// the last word has played for NOTE_CYC clocks.
//
// Ports:
//   clk            - clock
//   reset_l        - synchronous reset, active HIGH despite the name
//   start          - begin a load (honoured in IDLE, FULL, STOP_WORK)
//   sel_adr        - with start: 1 = load from i_i, 0 = load from address 0
//   i_i            - start address for load and play (>= DEPTH means 0)
//   valid          - data_to_memory holds a byte
//   data_to_memory - byte stream, least-significant byte first
//   enable_l       - play enable, level-sensitive, active high
//   req_f_rcv      - ready to receive bytes
//   full           - RAM loaded through its last address
//   i_o            - address of the word currently playing
//   note_o         - word currently playing
//   note_vld       - one-cycle pulse when a new note_o is presented
//
// N_BYTS must be at least 2; NOTE_CYC must be at least 2.
// -----------------------------------------------------------------------------
module prog_ram_player
    import prog_ram_pkg::*;
#(
    parameter int N_BYTS          = 2,
    parameter int NUM_OCTAV       = 1,
    parameter int WIDTH_NUM_OCTAV = $clog2(NUM_OCTAV * NOTES_PER_OCTAVE_C),
    parameter int NOTE_CYC        = 16
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       start,
    input  logic                       sel_adr,
    input  logic [WIDTH_NUM_OCTAV-1:0] i_i,
    input  logic                       valid,
    input  logic [7:0]                 data_to_memory,
    input  logic                       enable_l,
    output logic                       req_f_rcv,
    output logic                       full,
    output logic [WIDTH_NUM_OCTAV-1:0] i_o,
    output logic [N_BYTS*8-1:0]        note_o,
    output logic                       note_vld
);

    localparam int unsigned DEPTH  = depth_f(NUM_OCTAV);
    localparam int          W      = N_BYTS * 8;
    localparam int          PART_W = W - 8;
    localparam int          AW     = WIDTH_NUM_OCTAV;
    localparam int          BCNT_W = $clog2(N_BYTS);
    localparam int          TCNT_W = $clog2(NOTE_CYC);

    localparam logic [AW-1:0]     LAST_ADDR   = AW'(DEPTH - 1);
    localparam logic [AW-1:0]     ONE_A       = AW'(1'b1);
    localparam logic [BCNT_W-1:0] LAST_BYTE   = BCNT_W'(N_BYTS - 1);
    localparam logic [BCNT_W-1:0] ONE_B       = BCNT_W'(1'b1);
    localparam logic [TCNT_W-1:0] TICK_RELOAD = TCNT_W'(NOTE_CYC - 1);
    localparam logic [TCNT_W-1:0] ONE_T       = TCNT_W'(1'b1);

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [AW-1:0]       start_addr_q, start_addr_d;
    logic [AW-1:0]       i_o_q, i_o_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [PART_W-1:0]   part_q, part_d;
    logic [TCNT_W-1:0]   tick_q, tick_d;
    logic                full_q, full_d;
    logic                req_q;
    logic                note_vld_q, note_vld_d;
    logic                load_q, load_d;     // fresh read pending on next WORK edge
    logic                done_q, done_d;     // playback ran off the end

    logic [AW-1:0]       load_addr_s;
    logic [AW-1:0]       next_addr_s;
    logic [AW-1:0]       rd_addr_s;
    logic [AW-1:0]       mem_addr_s;
    logic [W-1:0]        word_s;
    logic                we_s;
    logic                re_s;
    logic                start_load_s;

    // Newest byte goes on top; earlier bytes sit below it, so the first byte
    // of a word ends up least significant.
    assign word_s      = {data_to_memory, part_q};
    assign next_addr_s = i_o_q + ONE_A;
    assign start_load_s = start & ((state_q == IDLE) | (state_q == FULL) |
                                   (state_q == STOP_WORK));

    // Start address for a new load; out-of-range requests fall back to 0.
    always_comb begin
        load_addr_s = {AW{1'b0}};
        if (sel_adr) begin
            if (32'(i_i) >= DEPTH) begin
                load_addr_s = {AW{1'b0}};
            end else begin
                load_addr_s = i_i;
            end
        end else begin
            load_addr_s = {AW{1'b0}};
        end
    end

    // Next-state logic for load and playback.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        start_addr_d = start_addr_q;
        i_o_d        = i_o_q;
        byte_cnt_d   = byte_cnt_q;
        part_d       = part_q;
        tick_d       = tick_q;
        full_d       = full_q;
        load_d       = load_q;
        done_d       = done_q;
        note_vld_d   = 1'b0;
        we_s         = 1'b0;
        re_s         = 1'b0;
        rd_addr_s    = i_o_q;

        if (start_load_s) begin
            state_d      = RCV;
            wr_addr_d    = load_addr_s;
            start_addr_d = load_addr_s;
            byte_cnt_d   = {BCNT_W{1'b0}};
            full_d       = 1'b0;
            load_d       = 1'b0;
            done_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RCV: begin
                    if (valid) begin
                        part_d = word_s[W-1:8];
                        if (byte_cnt_q == LAST_BYTE) begin
                            we_s       = 1'b1;
                            byte_cnt_d = {BCNT_W{1'b0}};
                            if (wr_addr_q == LAST_ADDR) begin
                                full_d  = 1'b1;
                                state_d = FULL;
                            end else begin
                                wr_addr_d = wr_addr_q + ONE_A;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + ONE_B;
                        end
                    end else begin
                        state_d = RCV;
                    end
                end
                FULL: begin
                    if (enable_l) begin
                        state_d = WORK;
                        i_o_d   = start_addr_q;
                        load_d  = 1'b1;
                    end else begin
                        state_d = FULL;
                    end
                end
                WORK: begin
                    if (!enable_l) begin
                        // Pause: address and note are held.
                        state_d = STOP_WORK;
                        load_d  = 1'b0;
                    end else if (load_q) begin
                        re_s       = 1'b1;
                        rd_addr_s  = i_o_q;
                        note_vld_d = 1'b1;
                        tick_d     = TICK_RELOAD;
                        load_d     = 1'b0;
                    end else if (tick_q == {TCNT_W{1'b0}}) begin
                        if (i_o_q == LAST_ADDR) begin
`ifdef PROG_RAM_LOOP_EN
                            re_s       = 1'b1;
                            rd_addr_s  = start_addr_q;
                            i_o_d      = start_addr_q;
                            note_vld_d = 1'b1;
                            tick_d     = TICK_RELOAD;
`else
                            state_d = STOP_WORK;
                            done_d  = 1'b1;
`endif
                        end else begin
                            re_s       = 1'b1;
                            rd_addr_s  = next_addr_s;
                            i_o_d      = next_addr_s;
                            note_vld_d = 1'b1;
                            tick_d     = TICK_RELOAD;
                        end
                    end else begin
                        tick_d = tick_q - ONE_T;
                    end
                end
                STOP_WORK: begin
                    if (done_q) begin
                        // After running off the end, a low enable re-arms
                        // playback from the start address.
                        if (!enable_l) begin
                            done_d = 1'b0;
                            i_o_d  = start_addr_q;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (enable_l) begin
                        state_d = WORK;
                        load_d  = 1'b1;
                    end else begin
                        state_d = STOP_WORK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Writes only happen while loading, so the port address follows the
    // write pointer in RCV and the playback address otherwise.
    assign mem_addr_s = (state_q == RCV) ? wr_addr_q : rd_addr_s;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset_l) begin
            state_q      <= IDLE;
            wr_addr_q    <= {AW{1'b0}};
            start_addr_q <= {AW{1'b0}};
            i_o_q        <= {AW{1'b0}};
            byte_cnt_q   <= {BCNT_W{1'b0}};
            part_q       <= {PART_W{1'b0}};
            tick_q       <= {TCNT_W{1'b0}};
            full_q       <= 1'b0;
            req_q        <= 1'b0;
            note_vld_q   <= 1'b0;
            load_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            start_addr_q <= start_addr_d;
            i_o_q        <= i_o_d;
            byte_cnt_q   <= byte_cnt_d;
            part_q       <= part_d;
            tick_q       <= tick_d;
            full_q       <= full_d;
            req_q        <= (state_d == RCV);
            note_vld_q   <= note_vld_d;
            load_q       <= load_d;
            done_q       <= done_d;
        end
    end

    prog_ram_mem #(
        .DW    (W),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .reset_i (reset_l),
        .we_i    (we_s & ~reset_l),
        .re_i    (re_s & ~reset_l),
        .addr_i  (mem_addr_s),
        .wdata_i (word_s),
        .rdata_o (note_o)
    );

    assign req_f_rcv = req_q;
    assign full      = full_q;
    assign i_o       = i_o_q;
    assign note_vld  = note_vld_q;

endmodule

// File: tb/tb_prog_ram_player.sv
// -----------------------------------------------------------------------------
// tb_prog_ram_player
// Directed bench for prog_ram_player with default parameters (2-byte words,
// 7-entry RAM, 16 clocks per note). Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_prog_ram_player;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        start;
    logic        sel_adr;
    logic [2:0]  i_i;
    logic        valid;
    logic [7:0]  data_to_memory;
    logic        enable_l;
    logic        req_f_rcv;
    logic        full;
    logic [2:0]  i_o;
    logic [15:0] note_o;
    logic        note_vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_ram_player #(
        .N_BYTS          (2),
        .NUM_OCTAV       (1),
        .WIDTH_NUM_OCTAV (3),
        .NOTE_CYC        (16)
    ) dut (
        .clk            (clk),
        .reset_l        (reset_l),
        .start          (start),
        .sel_adr        (sel_adr),
        .i_i            (i_i),
        .valid          (valid),
        .data_to_memory (data_to_memory),
        .enable_l       (enable_l),
        .req_f_rcv      (req_f_rcv),
        .full           (full),
        .i_o            (i_o),
        .note_o         (note_o),
        .note_vld       (note_vld)
    );

    // One byte presented for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        valid = 1'b1;
        data_to_memory = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Issue start for one rising edge.
    task automatic do_start(input logic sel, input logic [2:0] adr);
        sel_adr = sel;
        i_i = adr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        reset_l = 1'b0;
        checks++; if (req_f_rcv !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req_f_rcv); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (i_o !== 3'd0) begin errors++; $display("FAIL rst_i_o: got %0d want 0", i_o); end
        checks++; if (note_o !== 16'h0000) begin errors++; $display("FAIL rst_note: got %h want 0000", note_o); end
        checks++; if (note_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", note_vld); end
    endtask

    // Bytes 0x01..0x0E from address 0, one idle cycle between words.
    task automatic test_load_from_0();
        logic exp_full;
        do_start(1'b0, 3'd0);
        checks++; if (req_f_rcv !== 1'b1) begin errors++; $display("FAIL load0_req_rise: got %b want 1", req_f_rcv); end
        for (int n = 1; n <= 14; n++) begin
            send_byte(8'(n));
            exp_full = (n == 14);
            checks++; if (full !== exp_full) begin errors++; $display("FAIL load0_full byte %0d: got %b want %b", n, full, exp_full); end
            checks++; if (req_f_rcv !== !exp_full) begin errors++; $display("FAIL load0_req byte %0d: got %b want %b", n, req_f_rcv, !exp_full); end
            if ((n % 2 == 0) && (n != 14)) @(negedge clk);
        end
    endtask

    // Junk bytes in FULL are ignored, then play all words; start mid-play is ignored.
    task automatic test_play();
        logic        exp_vld;
        int          k;
        int          idx;
        logic [15:0] exp_note;
        valid = 1'b1;
        data_to_memory = 8'hFF;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_hold: got %b want 1", full); end
        checks++; if (req_f_rcv !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", req_f_rcv); end
        enable_l = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            k = (c - 2) / 16;
            exp_vld = (c >= 2) && ((c - 2) % 16 == 0);
`ifndef PROG_RAM_LOOP_EN
            if (k >= 7) exp_vld = 1'b0;
`endif
            idx = k % 7;
            exp_note = {8'(2 * idx + 2), 8'(2 * idx + 1)};
            checks++; if (note_vld !== exp_vld) begin errors++; $display("FAIL play_vld cycle %0d: got %b want %b", c, note_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if (i_o !== 3'(idx)) begin errors++; $display("FAIL play_i_o cycle %0d: got %0d want %0d", c, i_o, idx); end
                checks++; if (note_o !== exp_note) begin errors++; $display("FAIL play_note cycle %0d: got %h want %h", c, note_o, exp_note); end
            end
            checks++; if (req_f_rcv !== 1'b0) begin errors++; $display("FAIL play_req cycle %0d: got %b want 0", c, req_f_rcv); end
            start = (c == 9);
        end
        start = 1'b0;
    endtask

`ifndef PROG_RAM_LOOP_EN
    // After the end of play, enable low then high restarts at the start address.
    task automatic test_end_restart();
        enable_l = 1'b0;
        repeat (2) @(negedge clk);
        enable_l = 1'b1;
        @(negedge clk);
        checks++; if (note_vld !== 1'b0) begin errors++; $display("FAIL restart_early: got %b want 0", note_vld); end
        @(negedge clk);
        checks++; if (note_vld !== 1'b1) begin errors++; $display("FAIL restart_vld: got %b want 1", note_vld); end
        checks++; if (i_o !== 3'd0) begin errors++; $display("FAIL restart_i_o: got %0d want 0", i_o); end
        checks++; if (note_o !== 16'h0201) begin errors++; $display("FAIL restart_note: got %h want 0201", note_o); end
    endtask
`endif

    // Load two words at address 5, then play from 5.
    task automatic test_start_addr();
        logic exp_vld;
        logic [15:0] exp_note;
        int k;
        enable_l = 1'b0;
        repeat (2) @(negedge clk);
        do_start(1'b1, 3'd5);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL sa_full_clr: got %b want 0", full); end
        checks++; if (req_f_rcv !== 1'b1) begin errors++; $display("FAIL sa_req: got %b want 1", req_f_rcv); end
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL sa_full_early: got %b want 0", full); end
        send_byte(8'hA4);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL sa_full: got %b want 1", full); end
        checks++; if (req_f_rcv !== 1'b0) begin errors++; $display("FAIL sa_req_fall: got %b want 0", req_f_rcv); end
        enable_l = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            k = (c - 2) / 16;
            exp_vld = (c >= 2) && ((c - 2) % 16 == 0);
`ifndef PROG_RAM_LOOP_EN
            if (k >= 2) exp_vld = 1'b0;
`endif
            exp_note = ((k % 2) == 0) ? 16'hA2A1 : 16'hA4A3;
            checks++; if (note_vld !== exp_vld) begin errors++; $display("FAIL sa_vld cycle %0d: got %b want %b", c, note_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if (i_o !== 3'(5 + (k % 2))) begin errors++; $display("FAIL sa_i_o cycle %0d: got %0d want %0d", c, i_o, 5 + (k % 2)); end
                checks++; if (note_o !== exp_note) begin errors++; $display("FAIL sa_note cycle %0d: got %h want %h", c, note_o, exp_note); end
            end
        end
        enable_l = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Out-of-range start address loads from 0; pause at i_o = 3 and resume.
    task automatic test_pause_clamp();
        logic exp_vld;
        int k;
        do_start(1'b1, 3'd7);
        for (int n = 0; n < 14; n++) send_byte(8'(8'h21 + n));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL clamp_full: got %b want 1", full); end
        enable_l = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            k = (c - 2) / 16;
            exp_vld = (c >= 2) && ((c - 2) % 16 == 0);
            checks++; if (note_vld !== exp_vld) begin errors++; $display("FAIL pz_vld cycle %0d: got %b want %b", c, note_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if (i_o !== 3'(k)) begin errors++; $display("FAIL pz_i_o cycle %0d: got %0d want %0d", c, i_o, k); end
                checks++; if (note_o !== {8'(8'h22 + 2 * k), 8'(8'h21 + 2 * k)}) begin errors++; $display("FAIL pz_note cycle %0d: got %h want %h", c, note_o, {8'(8'h22 + 2 * k), 8'(8'h21 + 2 * k)}); end
            end
        end
        enable_l = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            checks++; if (note_vld !== 1'b0) begin errors++; $display("FAIL pause_vld cycle %0d: got %b want 0", j, note_vld); end
            checks++; if (i_o !== 3'd3) begin errors++; $display("FAIL pause_i_o cycle %0d: got %0d want 3", j, i_o); end
        end
        enable_l = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            exp_vld = (c == 2) || (c == 18);
            checks++; if (note_vld !== exp_vld) begin errors++; $display("FAIL resume_vld cycle %0d: got %b want %b", c, note_vld, exp_vld); end
            if (c == 2) begin
                checks++; if (i_o !== 3'd3) begin errors++; $display("FAIL resume_i_o: got %0d want 3", i_o); end
                checks++; if (note_o !== 16'h2827) begin errors++; $display("FAIL resume_note: got %h want 2827", note_o); end
            end
            if (c == 18) begin
                checks++; if (i_o !== 3'd4) begin errors++; $display("FAIL resume_next_i_o: got %0d want 4", i_o); end
                checks++; if (note_o !== 16'h2A29) begin errors++; $display("FAIL resume_next_note: got %h want 2A29", note_o); end
            end
        end
    endtask

    // Reset after three bytes, then a clean load from 0 must not see the stale byte.
    task automatic test_reset_mid_load();
        logic exp_vld;
        enable_l = 1'b0;
        @(negedge clk);
        do_start(1'b0, 3'd0);
        send_byte(8'h51);
        send_byte(8'h52);
        send_byte(8'h53);
        reset_l = 1'b1;
        @(negedge clk);
        reset_l = 1'b0;
        checks++; if (req_f_rcv !== 1'b0) begin errors++; $display("FAIL mrst_req: got %b want 0", req_f_rcv); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL mrst_full: got %b want 0", full); end
        checks++; if (i_o !== 3'd0) begin errors++; $display("FAIL mrst_i_o: got %0d want 0", i_o); end
        checks++; if (note_o !== 16'h0000) begin errors++; $display("FAIL mrst_note: got %h want 0000", note_o); end
        checks++; if (note_vld !== 1'b0) begin errors++; $display("FAIL mrst_vld: got %b want 0", note_vld); end
        do_start(1'b0, 3'd0);
        for (int n = 0; n < 14; n++) send_byte(8'(8'h31 + n));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL mrst_full_reload: got %b want 1", full); end
        enable_l = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            exp_vld = (c == 2) || (c == 18);
            checks++; if (note_vld !== exp_vld) begin errors++; $display("FAIL mrst_play_vld cycle %0d: got %b want %b", c, note_vld, exp_vld); end
            if (c == 2) begin
                checks++; if (note_o !== 16'h3231) begin errors++; $display("FAIL mrst_word0: got %h want 3231", note_o); end
            end
            if (c == 18) begin
                checks++; if (note_o !== 16'h3433) begin errors++; $display("FAIL mrst_word1: got %h want 3433", note_o); end
            end
        end
        enable_l = 1'b0;
    endtask

    initial begin
        reset_l = 1'b1;
        start = 1'b0;
        sel_adr = 1'b0;
        i_i = 3'd0;
        valid = 1'b0;
        data_to_memory = 8'h00;
        enable_l = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_from_0();
        test_play();
`ifndef PROG_RAM_LOOP_EN
        test_end_restart();
`endif
        test_start_addr();
        test_pause_clamp();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
